// File: rtl/nic_wb_slave_rx.sv
// WISHBONE pipelined-mode slave at the NIC bus port: gathers write bursts into messages for the
// core and streams read replies back. Optional retry mode is enabled with `define NIC_WB_RX_RETRY_EN.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 4
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef FLIT_TYPE_BITS
`define FLIT_TYPE_BITS 31:30
`endif
`ifndef HEAD_FLIT
`define HEAD_FLIT 2'b10
`endif
`ifndef BODY_FLIT
`define BODY_FLIT 2'b00
`endif
`ifndef TAIL_FLIT
`define TAIL_FLIT 2'b01
`endif
`ifndef HEAD_TAIL_FLIT
`define HEAD_TAIL_FLIT 2'b11
`endif

module nic_wb_slave_rx #(
  parameter int DATA_WIDTH = `BUS_DATA_WIDTH,
  parameter int MAX_BURST  = `MAX_BURST_LENGHT,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CYC_I,
  input  logic                            STB_I,
  input  logic                            WE_I,
  input  logic [DATA_WIDTH-1:0]           DAT_I,
  input  logic [`BUS_ADDRESS_WIDTH-1:0]   ADR_I,
  input  logic [`BUS_SEL_WIDTH-1:0]       SEL_I,
  output logic [DATA_WIDTH-1:0]           DAT_O,
  output logic                            ACK_O,
  output logic                            ERR_O,
  output logic                            RTY_O,
  output logic                            STALL_O,
  output logic                            msg_valid_o,
  input  logic                            msg_ready_i,
  output logic [DATA_WIDTH*MAX_BURST-1:0] msg_data_o,
  output logic [LEN_WIDTH-1:0]            msg_len_o,
  output logic                            msg_is_read_o,
  input  logic                            reply_valid_i,
  input  logic [DATA_WIDTH-1:0]           reply_data_i,
  output logic                            reply_ready_o
);

  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_HOLD, S_WAIT_REPLY, S_REPLY
  } state_t;

  state_t                          r_state;
  logic [DATA_WIDTH*MAX_BURST-1:0] r_buf;
  logic [LEN_WIDTH-1:0]            r_cnt;
  logic [LEN_WIDTH-1:0]            r_len;
  logic [LEN_WIDTH-1:0]            r_reply_cnt;
  logic                            r_is_read;
  logic                            r_msg_valid;
  logic                            r_ack;
  logic                            r_err;
  logic [DATA_WIDTH-1:0]           r_dat;
  logic [`BUS_ADDRESS_WIDTH-1:0]   r_adr;

  logic                            w_busy;
  logic                            w_beat;
  logic                            w_reply_take;
  logic [1:0]                      w_type;
  logic [LEN_WIDTH-1:0]            w_cnt_nxt;
  logic [IDX_W-1:0]                w_idx;
  logic                            w_unused;

  assign w_busy       = (r_state == S_HOLD) || (r_state == S_WAIT_REPLY) || (r_state == S_REPLY);
  assign w_type       = DAT_I[`FLIT_TYPE_BITS];
  assign w_cnt_nxt    = r_cnt + 1'b1;
  assign w_idx        = r_cnt[IDX_W-1:0];
  assign w_beat       = CYC_I & STB_I & ~STALL_O;
  assign w_reply_take = ((r_state == S_WAIT_REPLY) || (r_state == S_REPLY)) & reply_valid_i & CYC_I;
  assign w_unused     = ^{SEL_I, r_adr};

`ifdef NIC_WB_RX_RETRY_EN
  logic r_rty;

  // Busy is reported through RTY instead of holding the bus with STALL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rty <= 1'b0;
    else     r_rty <= w_busy & CYC_I & STB_I;
  end

  assign RTY_O   = r_rty;
  assign STALL_O = 1'b0;
`else
  assign RTY_O   = 1'b0;
  assign STALL_O = w_busy;
`endif

  assign DAT_O         = r_dat;
  assign ACK_O         = r_ack;
  assign ERR_O         = r_err;
  assign msg_valid_o   = r_msg_valid;
  assign msg_data_o    = r_buf;
  assign msg_len_o     = r_len;
  assign msg_is_read_o = r_is_read;
  assign reply_ready_o = w_reply_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_reply_cnt <= '0;
      r_is_read   <= 1'b0;
      r_msg_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dat       <= '0;
      r_adr       <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_adr <= ADR_I;
            if (!WE_I) begin
              r_buf[DATA_WIDTH-1:0] <= DAT_I;
              r_cnt       <= LEN_WIDTH'(1);
              r_len       <= LEN_WIDTH'(1);
              r_is_read   <= 1'b1;
              r_msg_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else if (w_type == `HEAD_TAIL_FLIT) begin
              r_buf[DATA_WIDTH-1:0] <= DAT_I;
              r_cnt       <= LEN_WIDTH'(1);
              r_len       <= LEN_WIDTH'(1);
              r_ack       <= 1'b1;
              r_msg_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else if (w_type == `HEAD_FLIT) begin
              r_buf[DATA_WIDTH-1:0] <= DAT_I;
              r_cnt   <= LEN_WIDTH'(1);
              r_ack   <= 1'b1;
              r_state <= S_RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          // A master abandoning its cycle silently discards the partial message.
          if (!CYC_I) begin
            r_buf <= '0; r_cnt <= '0; r_state <= S_IDLE;
          end else if (w_beat && !WE_I) begin
            r_err <= 1'b1;
          end else if (w_beat) begin
            r_buf[w_idx*DATA_WIDTH +: DATA_WIDTH] <= DAT_I;
            r_cnt <= w_cnt_nxt;
            if (w_type == `TAIL_FLIT) begin
              r_ack       <= 1'b1;
              r_len       <= w_cnt_nxt;
              r_msg_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else if (w_cnt_nxt == LEN_WIDTH'(MAX_BURST)) begin
              r_err <= 1'b1;
              r_buf <= '0; r_cnt <= '0; r_state <= S_IDLE;
            end else begin
              r_ack <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (msg_ready_i) begin
            r_msg_valid <= 1'b0;
            if (r_is_read) begin
              r_reply_cnt <= '0;
              r_state     <= S_WAIT_REPLY;
            end else begin
              r_buf <= '0; r_cnt <= '0; r_len <= '0; r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_REPLY, S_REPLY: begin
          if (!CYC_I) begin
            r_buf <= '0; r_cnt <= '0; r_len <= '0; r_is_read <= 1'b0; r_state <= S_IDLE;
          end else if (w_reply_take) begin
            r_dat       <= reply_data_i;
            r_ack       <= 1'b1;
            r_reply_cnt <= r_reply_cnt + 1'b1;
            if (r_reply_cnt == LEN_WIDTH'(MAX_BURST - 1)) begin
              r_buf <= '0; r_cnt <= '0; r_len <= '0; r_is_read <= 1'b0; r_state <= S_IDLE;
            end else begin
              r_state <= S_REPLY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_wb_slave_rx.sv
// Bench for nic_wb_slave_rx: a queue-based message model checked every cycle, plus directed
// scenarios with literal expectations.
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif

module tb_nic_wb_slave_rx;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int LW = 4;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HT   = 2'b11;
`ifdef NIC_WB_RX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          CYC_I, STB_I, WE_I;
  logic [DW-1:0]                 DAT_I;
  logic [`BUS_ADDRESS_WIDTH-1:0] ADR_I;
  logic [`BUS_SEL_WIDTH-1:0]     SEL_I;
  logic [DW-1:0]                 DAT_O;
  logic                          ACK_O, ERR_O, RTY_O, STALL_O;
  logic                          msg_valid_o, msg_ready_i;
  logic [DW*MB-1:0]              msg_data_o;
  logic [LW-1:0]                 msg_len_o;
  logic                          msg_is_read_o;
  logic                          reply_valid_i;
  logic [DW-1:0]                 reply_data_i;
  logic                          reply_ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  nic_wb_slave_rx #(.DATA_WIDTH(DW), .MAX_BURST(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .DAT_I(DAT_I),
    .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O),
    .STALL_O(STALL_O), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .msg_data_o(msg_data_o), .msg_len_o(msg_len_o), .msg_is_read_o(msg_is_read_o),
    .reply_valid_i(reply_valid_i), .reply_data_i(reply_data_i), .reply_ready_o(reply_ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkm(input string name, input logic [DW*MB-1:0] act, input logic [DW*MB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 message held, 3 returning replies.
  int            m_phase;
  logic [DW-1:0] m_q[$];
  bit            m_is_read;
  int            m_replies;
  bit            e_ack, e_err, e_rty;
  logic [DW-1:0] e_dat;

  function automatic logic [DW*MB-1:0] packed_msg();
    logic [DW*MB-1:0] v = '0;
    for (int i = 0; i < m_q.size(); i++) v[i*DW +: DW] = m_q[i];
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_is_read = 1'b0;
    m_phase   = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_replies = 0;
    e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0;
    e_dat = '0;
  endtask

  task automatic model_step();
    int         ph;
    bit         beat;
    logic [1:0] t;
    ph    = m_phase;
    e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0;
    beat  = CYC_I && STB_I && !(ph >= 2 && !RETRY);
    t     = DAT_I[31:30];
    if (RETRY && ph >= 2 && CYC_I && STB_I) e_rty = 1'b1;
    if (ph == 0) begin
      if (beat && !WE_I) begin
        m_q = {DAT_I}; m_is_read = 1'b1; m_phase = 2;
      end else if (beat && t == T_HT) begin
        m_q = {DAT_I}; e_ack = 1'b1; m_phase = 2;
      end else if (beat && t == T_HEAD) begin
        m_q = {DAT_I}; e_ack = 1'b1; m_phase = 1;
      end else if (beat) begin
        e_err = 1'b1;
      end
    end else if (ph == 1) begin
      if (!CYC_I) model_clear();
      else if (beat && !WE_I) e_err = 1'b1;
      else if (beat) begin
        m_q.push_back(DAT_I);
        if (t == T_TAIL) begin
          e_ack = 1'b1; m_phase = 2;
        end else if (m_q.size() == MB) begin
          e_err = 1'b1; model_clear();
        end else e_ack = 1'b1;
      end
    end else if (ph == 2) begin
      if (msg_ready_i) begin
        if (m_is_read) begin
          m_phase = 3; m_replies = 0;
        end else model_clear();
      end
    end else begin
      if (!CYC_I) model_clear();
      else if (reply_valid_i) begin
        e_dat = reply_data_i; e_ack = 1'b1; m_replies++;
        if (m_replies == MB) model_clear();
      end
    end
  endtask

  task automatic compare();
    chk1("ACK_O", ACK_O, e_ack);
    chk1("ERR_O", ERR_O, e_err);
    chk1("RTY_O", RTY_O, e_rty);
    chk1("ACK_ERR_exclusive", ACK_O & ERR_O, 1'b0);
    chk1("STALL_O", STALL_O, !RETRY && m_phase >= 2);
    chk1("msg_valid_o", msg_valid_o, m_phase == 2);
    chk1("reply_ready_o", reply_ready_o, m_phase == 3 && reply_valid_i && CYC_I);
    chkw("DAT_O", DAT_O, e_dat);
    chkm("msg_data_o", msg_data_o, packed_msg());
    if (m_phase == 2) begin
      chkw("msg_len_o", 32'(msg_len_o), 32'(m_q.size()));
      chk1("msg_is_read_o", msg_is_read_o, m_is_read);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) model_reset();
      else     model_step();
      if (cmp_en) compare();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic step(input logic cyc, input logic stb, input logic we, input logic [DW-1:0] d);
    @(negedge clk);
    CYC_I = cyc; STB_I = stb; WE_I = we; DAT_I = d;
  endtask

  task automatic ready_pulse();
    @(negedge clk); msg_ready_i = 1'b1;
    @(negedge clk); msg_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
    ADR_I = 32'h0000_0100; SEL_I = '1;
    msg_ready_i = 1'b0; reply_valid_i = 1'b0; reply_data_i = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk1("rst_ack", ACK_O, 1'b0);
    chk1("rst_valid", msg_valid_o, 1'b0);
    chk1("rst_stall", STALL_O, 1'b0);
    chkm("rst_data", msg_data_o, '0);
    @(negedge clk); rst = 1'b0;

    // Single HEAD_TAIL write
    step(1, 1, 1, 32'hC000_1234);
    step(1, 0, 0, 0);
    chk1("ht_ack", ACK_O, 1'b1);
    step(0, 0, 0, 0);
    chk1("ht_valid", msg_valid_o, 1'b1);
    chkw("ht_len", 32'(msg_len_o), 32'd1);
    chkw("ht_word0", msg_data_o[31:0], 32'hC000_1234);
    chk1("ht_stall", STALL_O, !RETRY);
    ready_pulse();
    chk1("ht_stall_after", STALL_O, 1'b0);

    // Four-word burst
    step(1, 1, 1, 32'h8000_0001);
    step(1, 1, 1, 32'h0000_0002);
    step(1, 1, 1, 32'h0000_0003);
    step(1, 1, 1, 32'h4000_0004);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chkw("burst_len", 32'(msg_len_o), 32'd4);
    chkm("burst_data", msg_data_o, {32'h4000_0004, 32'h0000_0003, 32'h0000_0002, 32'h8000_0001});
    ready_pulse();

    // Read command and four replies
    step(1, 1, 0, 32'hABCD_0010);
    step(1, 0, 0, 0);
    chk1("rd_no_ack", ACK_O, 1'b0);
    chk1("rd_is_read", msg_is_read_o, 1'b1);
    chkw("rd_word0", msg_data_o[31:0], 32'hABCD_0010);
    ready_pulse();
    for (int i = 1; i <= MB; i++) begin
      @(negedge clk);
      if (i > 1) chkw("rd_dat", DAT_O, 32'(i - 1));
      reply_valid_i = 1'b1; reply_data_i = 32'(i);
    end
    @(negedge clk);
    chkw("rd_dat_last", DAT_O, 32'd4);
    chk1("rd_ack_last", ACK_O, 1'b1);
    reply_valid_i = 1'b0;
    step(0, 0, 0, 0);
    chk1("rd_idle_stall", STALL_O, 1'b0);

    // BODY without a head
    step(1, 1, 1, 32'h0000_0055);
    step(0, 0, 0, 0);
    chk1("body_first_err", ERR_O, 1'b1);
    chk1("body_first_noack", ACK_O, 1'b0);
    step(0, 0, 0, 0);
    chk1("body_first_novalid", msg_valid_o, 1'b0);

    // Burst overflow without TAIL
    step(1, 1, 1, 32'h8000_0011);
    step(1, 1, 1, 32'h0000_0012);
    step(1, 1, 1, 32'h0000_0013);
    step(1, 1, 1, 32'h0000_0014);
    step(1, 0, 0, 0);
    chk1("ovf_err", ERR_O, 1'b1);
    chk1("ovf_noack", ACK_O, 1'b0);
    chkm("ovf_cleared", msg_data_o, '0);
    step(0, 0, 0, 0);
    chk1("ovf_novalid", msg_valid_o, 1'b0);

    // CYC dropped mid-burst, then a clean single-word write
    step(1, 1, 1, 32'h8000_0021);
    step(1, 1, 1, 32'h0000_0022);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chkm("drop_cleared", msg_data_o, '0);
    chk1("drop_novalid", msg_valid_o, 1'b0);
    step(1, 1, 1, 32'hC000_00AA);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chkw("drop_next_len", 32'(msg_len_o), 32'd1);
    chkm("drop_next_data", msg_data_o, {96'h0, 32'hC000_00AA});
    ready_pulse();

    // New strobe while a message is held
    step(1, 1, 1, 32'hC000_0077);
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h8000_0099);
    step(1, 0, 0, 0);
    chk1("busy_rty", RTY_O, RETRY);
    chk1("busy_stall", STALL_O, !RETRY);
    chkw("busy_word0", msg_data_o[31:0], 32'hC000_0077);
    @(negedge clk);
    msg_ready_i = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 32'hC000_0088;
    @(negedge clk);
    msg_ready_i = 1'b0;
    @(negedge clk);
    STB_I = 1'b0;
    chk1("overlap_ack", ACK_O, 1'b1);
    chkw("overlap_word0", msg_data_o[31:0], 32'hC000_0088);
    step(0, 0, 0, 0);
    ready_pulse();

    // Asynchronous reset mid-burst with an ACK pending
    step(1, 1, 1, 32'h8000_0031);
    step(1, 1, 1, 32'h0000_0032);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("arst_ack_lost", ACK_O, 1'b0);
    chkm("arst_data", msg_data_o, '0);
    @(negedge clk);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
    rst = 1'b0;
    step(1, 1, 1, 32'hC000_00EE);
    step(0, 0, 0, 0);
    chkw("arst_next_word0", msg_data_o[31:0], 32'hC000_00EE);
    ready_pulse();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
